// File: rtl/cbus_addr_xlat_stage.sv
// rtl/cbus_addr_xlat_stage.sv - registered CBus stage with kseg0/kseg1 address translation
//
// Captures one arbitrated CBus request and maps kseg0/kseg1 virtual addresses
// to physical ones. Then it holds the translated request on oreq and forwards
// downstream response beats to iresp until the last beat.
//
// Ports:
//   clk      - clock
//   resetn   - asynchronous active-low reset
//   ireq     - upstream request from the arbiter
//   iresp    - upstream response; all-zero while idle
//   oreq     - downstream translated request, stable for the whole transaction
//   oresp    - downstream response
//   uncached - 1 while the held transaction came from kseg1
//   busy     - 1 while a transaction is held
//   beat_err - sticky beat-count protocol error
//
// Optional feature: define CBUS_XLAT_CHECK_EN to build the beat checker.
// Without it beat_err is tied low and no beat counter exists.

package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_addr_xlat_stage
  import cbus_pkg::*;
#(
  parameter bit          PASSTHRU  = 1'b0,
  parameter logic [31:0] PHYS_MASK = 32'h1FFF_FFFF
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  ireq,
  output cbus_resp_t iresp,
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp,
  output logic       uncached,
  output logic       busy,
  output logic       beat_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t    state_q, state_d;
  cbus_req_t held_q, held_d;
  logic      uncached_q, uncached_d;

  logic [2:0]  seg;
  logic        is_unmapped;
  logic        is_kseg1;
  logic [31:0] xlat_addr;

  // kseg0 = 3'b100 and kseg1 = 3'b101 are the unmapped windows; all else passes through.
  assign seg         = ireq.addr[31:29];
  assign is_unmapped = !PASSTHRU && (seg[2:1] == 2'b10);
  assign is_kseg1    = !PASSTHRU && (seg == 3'b101);
  assign xlat_addr   = is_unmapped ? (ireq.addr & PHYS_MASK) : ireq.addr;

  wire   end_beat    = (state_q == BUSY) && oresp.ready && oresp.last;

  always_comb begin
    state_d    = state_q;
    held_d     = held_q;
    uncached_d = uncached_q;
    case (state_q)
      IDLE: begin
        if (ireq.valid) begin
          held_d      = ireq;
          held_d.addr = xlat_addr;
          uncached_d  = is_kseg1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (end_beat) begin
          held_d.valid = 1'b0;
          uncached_d   = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      held_q     <= '0;
      uncached_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      uncached_q <= uncached_d;
    end
  end

  assign oreq     = held_q;
  assign busy     = (state_q == BUSY);
  assign uncached = uncached_q;
  // Responses only flow while a transaction is held; stray idle beats are dropped.
  assign iresp    = busy ? oresp : '0;

`ifdef CBUS_XLAT_CHECK_EN
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       beat_err_q, beat_err_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    beat_err_d = beat_err_q;
    if ((state_q == IDLE) && ireq.valid) begin
      beat_cnt_d = 8'd0;
    end else if ((state_q == BUSY) && oresp.ready) begin
      if (beat_cnt_q != 8'hFF) beat_cnt_d = beat_cnt_q + 8'd1;
      // beat_cnt_q counts beats already taken, so the last beat must see cnt == len.
      if (oresp.last && (beat_cnt_q != held_q.len)) beat_err_d = 1'b1;
      if (!oresp.last && (beat_cnt_q >= held_q.len)) beat_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_cnt_q <= 8'd0;
      beat_err_q <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      beat_err_q <= beat_err_d;
    end
  end

  assign beat_err = beat_err_q;
`else
  assign beat_err = 1'b0;
`endif

endmodule

// File: tb/tb_cbus_addr_xlat_stage.sv
// tb/tb_cbus_addr_xlat_stage.sv - self-checking bench for cbus_addr_xlat_stage
module tb_cbus_addr_xlat_stage;
  import cbus_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  cbus_req_t  ireq;
  cbus_resp_t oresp;
  cbus_resp_t iresp, iresp_pt;
  cbus_req_t  oreq, oreq_pt;
  logic       uncached, uncached_pt;
  logic       busy, busy_pt;
  logic       beat_err, beat_err_pt;

  int checks = 0;
  int errors = 0;

  cbus_req_t   exp_req_q[$];
  logic [31:0] exp_data_q[$];

`ifdef CBUS_XLAT_CHECK_EN
  localparam logic CHECK_ON = 1'b1;
`else
  localparam logic CHECK_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  cbus_addr_xlat_stage #(.PASSTHRU(1'b0)) u_dut (
    .clk(clk), .resetn(resetn), .ireq(ireq), .iresp(iresp), .oreq(oreq),
    .oresp(oresp), .uncached(uncached), .busy(busy), .beat_err(beat_err)
  );

  cbus_addr_xlat_stage #(.PASSTHRU(1'b1)) u_dut_pt (
    .clk(clk), .resetn(resetn), .ireq(ireq), .iresp(iresp_pt), .oreq(oreq_pt),
    .oresp(oresp), .uncached(uncached_pt), .busy(busy_pt), .beat_err(beat_err_pt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic cbus_req_t mk_req(input logic [31:0] addr, input logic we, input logic [7:0] len,
                                       input logic [3:0] strb, input logic [31:0] data, input logic [1:0] burst);
    cbus_req_t r;
    r.valid = 1'b1; r.is_write = we; r.size = 3'd2; r.addr = addr;
    r.strobe = strb; r.data = data; r.len = len; r.burst = burst;
    return r;
  endfunction

  // Reference translation: kseg0/kseg1 lose their top three bits unless passthrough.
  function automatic cbus_req_t model(input cbus_req_t r, input bit pt);
    cbus_req_t m = r;
    if (!pt && (r.addr[31:30] == 2'b10)) m.addr = {3'b000, r.addr[28:0]};
    return m;
  endfunction

  // Present a request and record the translated request the stage must hold.
  task automatic drive_req(input cbus_req_t r);
    ireq = r;
    exp_req_q.push_back(model(r, 1'b0));
  endtask

  task automatic test_reset();
    resetn = 1'b0; ireq = '0; oresp = '0;
    repeat (3) step();
    checks++; if (oreq !== '0)     begin errors++; $display("FAIL reset_oreq got=%h exp=0", oreq); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (uncached !== 1'b0) begin errors++; $display("FAIL reset_uncached got=%b exp=0", uncached); end
    checks++; if (beat_err !== 1'b0) begin errors++; $display("FAIL reset_beat_err got=%b exp=0", beat_err); end
    checks++; if (iresp !== '0)    begin errors++; $display("FAIL reset_iresp got=%h exp=0", iresp); end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    cbus_req_t e;
    drive_req(mk_req(32'hBFC0_0000, 1'b0, 8'd0, 4'hF, 32'h0, 2'd0));
    checks++; if (oreq.valid !== 1'b0) begin errors++; $display("FAIL sr_latency got=%b exp=0", oreq.valid); end
    step();
    e = exp_req_q.pop_front();
    checks++; if (oreq !== e) begin errors++; $display("FAIL sr_oreq got=%h exp=%h", oreq, e); end
    checks++; if (oreq.addr !== 32'h1FC0_0000) begin errors++; $display("FAIL sr_addr got=%h exp=1fc00000", oreq.addr); end
    checks++; if (uncached !== 1'b1) begin errors++; $display("FAIL sr_uncached got=%b exp=1", uncached); end
    oresp = '{ready: 1'b1, last: 1'b1, data: 32'hDEAD_BEEF};
    exp_data_q.push_back(32'hDEAD_BEEF);
    #1;
    checks++;
    if (iresp.ready !== 1'b1 || iresp.last !== 1'b1 || iresp.data !== exp_data_q[0]) begin
      errors++; $display("FAIL sr_iresp got=%h exp_data=%h", iresp, exp_data_q[0]);
    end
    void'(exp_data_q.pop_front());
    step();
    ireq = '0;
    // oresp still asserted here: an idle stage must not forward it.
    checks++; if (iresp !== '0) begin errors++; $display("FAIL sr_idle_iresp got=%h exp=0", iresp); end
    checks++; if (busy !== 1'b0 || uncached !== 1'b0 || oreq.valid !== 1'b0) begin
      errors++; $display("FAIL sr_done got busy=%b unc=%b valid=%b exp=0,0,0", busy, uncached, oreq.valid);
    end
    oresp = '0;
    step();
  endtask

  task automatic test_kseg0_burst();
    cbus_req_t e;
    drive_req(mk_req(32'h8000_1000, 1'b0, 8'd3, 4'hF, 32'h0, 2'd1));
    step();
    e = exp_req_q.pop_front();
    checks++; if (oreq !== e || oreq.addr !== 32'h0000_1000) begin errors++; $display("FAIL k0_oreq got=%h exp=%h", oreq, e); end
    checks++; if (uncached !== 1'b0) begin errors++; $display("FAIL k0_uncached got=%b exp=0", uncached); end
    for (int i = 0; i < 4; i++) begin
      oresp = '{ready: 1'b1, last: (i == 3), data: 32'hC0DE_0000 + i};
      exp_data_q.push_back(32'hC0DE_0000 + i);
      #1;
      checks++;
      if (iresp.ready !== 1'b1 || iresp.last !== (i == 3) || iresp.data !== exp_data_q[0] || oreq !== e) begin
        errors++; $display("FAIL k0_beat%0d got=%h exp_data=%h", i, iresp, exp_data_q[0]);
      end
      void'(exp_data_q.pop_front());
      step();
    end
    ireq = '0; oresp = '0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL k0_idle got=%b exp=0", busy); end
    checks++; if (beat_err !== 1'b0) begin errors++; $display("FAIL k0_beat_err got=%b exp=0", beat_err); end
    step();
  endtask

  task automatic one_beat_done();
    oresp = '{ready: 1'b1, last: 1'b1, data: 32'h5A5A_5A5A};
    step();
    ireq = '0; oresp = '0;
    step();
  endtask

  task automatic test_kuseg_passthru();
    cbus_req_t e;
    drive_req(mk_req(32'h0040_0000, 1'b0, 8'd0, 4'hF, 32'h0, 2'd0));
    step();
    e = exp_req_q.pop_front();
    checks++; if (oreq.addr !== 32'h0040_0000 || oreq !== e) begin errors++; $display("FAIL kuseg_addr got=%h exp=00400000", oreq.addr); end
    one_beat_done();
    drive_req(mk_req(32'hA000_0000, 1'b0, 8'd0, 4'hF, 32'h0, 2'd0));
    step();
    e = exp_req_q.pop_front();
    checks++; if (oreq !== e) begin errors++; $display("FAIL kseg1_addr got=%h exp=%h", oreq.addr, e.addr); end
    checks++; if (oreq_pt !== model(ireq, 1'b1) || oreq_pt.addr !== 32'hA000_0000) begin
      errors++; $display("FAIL pt_addr got=%h exp=a0000000", oreq_pt.addr);
    end
    checks++; if (busy_pt !== 1'b1) begin errors++; $display("FAIL pt_busy got=%b exp=1", busy_pt); end
    oresp = '{ready: 1'b1, last: 1'b1, data: 32'h1234_5678};
    #1;
    checks++; if (iresp_pt.data !== 32'h1234_5678) begin errors++; $display("FAIL pt_iresp got=%h exp=12345678", iresp_pt.data); end
    step();
    ireq = '0; oresp = '0;
    step();
  endtask

  task automatic test_back_to_back();
    cbus_req_t e;
    int cyc;
    drive_req(mk_req(32'h8000_0010, 1'b1, 8'd0, 4'hF, 32'h1111_2222, 2'd0));
    step();
    e = exp_req_q.pop_front();
    checks++; if (oreq !== e) begin errors++; $display("FAIL b2b_wr got=%h exp=%h", oreq, e); end
    oresp = '{ready: 1'b1, last: 1'b1, data: 32'h0};
    cyc = 0;
    step(); cyc++;
    oresp = '0;
    drive_req(mk_req(32'h8000_0020, 1'b0, 8'd0, 4'h0, 32'h0, 2'd0));
    while (!oreq.valid && cyc < 10) begin step(); cyc++; end
    checks++; if (cyc !== 2) begin errors++; $display("FAIL b2b_latency got=%0d exp=2", cyc); end
    e = exp_req_q.pop_front();
    checks++; if (oreq !== e) begin errors++; $display("FAIL b2b_rd got=%h exp=%h", oreq, e); end
    one_beat_done();
  endtask

  task automatic test_reset_mid_burst();
    drive_req(mk_req(32'h8000_2000, 1'b0, 8'd7, 4'hF, 32'h0, 2'd1));
    step();
    void'(exp_req_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      oresp = '{ready: 1'b1, last: 1'b0, data: 32'h0000_0100 + i};
      step();
    end
    resetn = 1'b0;
    #1;
    checks++; if (oreq.valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid got valid=%b busy=%b exp=0,0", oreq.valid, busy);
    end
    step();
    ireq = '0;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (iresp.ready !== 1'b0) begin errors++; $display("FAIL rst_no_resp%0d got=%b exp=0", i, iresp.ready); end
    end
    oresp = '0;
    step();
  endtask

  task automatic test_beat_err();
    drive_req(mk_req(32'h8000_3000, 1'b0, 8'd3, 4'hF, 32'h0, 2'd1));
    step();
    void'(exp_req_q.pop_front());
    oresp = '{ready: 1'b1, last: 1'b0, data: 32'h1};
    step();
    oresp = '{ready: 1'b1, last: 1'b1, data: 32'h2};
    step();
    ireq = '0; oresp = '0;
    checks++; if (beat_err !== CHECK_ON) begin errors++; $display("FAIL berr_set got=%b exp=%b", beat_err, CHECK_ON); end
    repeat (4) step();
    checks++; if (beat_err !== CHECK_ON) begin errors++; $display("FAIL berr_sticky got=%b exp=%b", beat_err, CHECK_ON); end
    checks++; if (beat_err_pt !== CHECK_ON) begin errors++; $display("FAIL berr_pt got=%b exp=%b", beat_err_pt, CHECK_ON); end
    resetn = 1'b0;
    #1;
    checks++; if (beat_err !== 1'b0) begin errors++; $display("FAIL berr_clear got=%b exp=0", beat_err); end
    step();
    resetn = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_kseg0_burst();
    test_kuseg_passthru();
    test_back_to_back();
    test_reset_mid_burst();
    test_beat_err();
    checks++;
    if (exp_req_q.size() != 0 || exp_data_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got=%0d/%0d exp=0/0", exp_req_q.size(), exp_data_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
